// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
// Holds the state encoding and the rotating-priority winner pick.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Scan last_ptr+1 .. last_ptr+4 (mod 4); the nearest set bit wins.
  // The loop runs far-to-near so the nearest candidate overwrites the rest.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   last_ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = last_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last_ptr + SEL_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/data bundle between the requesters and the mux arbiter.
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               valid;
  logic               y_out;
  logic               timeout;

  modport master (
    output req, data_in,
    input  grant, sel, valid, y_out, timeout
  );

  modport slave (
    input  req, data_in,
    output grant, sel, valid, y_out, timeout
  );

endinterface

// File: rtl/mux4_rr_arbiter_sel_path.sv
// 4:1 bit-select datapath: forwards data_in[sel] only while a grant is active.
module mux4_sel_path
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] data_in_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               valid_i,
  output logic               y_out_o
);

  assign y_out_o = valid_i & data_in_i[sel_i];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning one 4:1 mux path; owner holds until it drops req.
// Optional forced release after MAX_HOLD busy cycles when ARB_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; arbitrate among req on the next edge (dead cycle)
// ST_BUSY | grant held by requester sel until it drops req (or times out)
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   bus
);

  if ((1 << CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_ptr_q, last_ptr_d;
  logic [SEL_W-1:0]   winner;
  logic               valid;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_ptr_d = last_ptr_q;
    winner     = rr_pick(bus.req, last_ptr_q);
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_d    = NUM_REQ'(1) << winner;
          sel_d      = winner;
          state_d    = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      ST_BUSY: begin
        // sel is left untouched on release; only grant/valid gate the path
        if (!bus.req[sel_q]) begin
          grant_d    = '0;
          last_ptr_d = sel_q;
          state_d    = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          grant_d    = '0;
          last_ptr_d = sel_q;
          timeout_d  = 1'b1;
          state_d    = ST_IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_ptr_q <= SEL_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_ptr_q <= last_ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign valid     = |grant_q;
  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  mux4_sel_path u_sel_path (
    .data_in_i (bus.data_in),
    .sel_i     (sel_q),
    .valid_i   (valid),
    .y_out_o   (bus.y_out)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic against an owner/pointer reference model. Honours ARB_TIMEOUT_EN.
module tb_mux4_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;
  localparam int TB_CNT_W    = 3;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  mux4_rr_arbiter_if bus_if ();

  mux4_rr_arbiter #(
    .MAX_HOLD (TB_MAX_HOLD),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner = -1 when nobody holds the path.
  int m_owner;
  int m_last;
  int m_sel;
  int m_hold;
  bit m_to;

  function automatic bit timeout_built();
`ifdef ARB_TIMEOUT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rn);
    if (!rn) begin
      m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        for (int k = 4; k >= 1; k--)
          if (r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        if (m_owner >= 0) begin
          m_sel = m_owner; m_hold = 0;
        end
      end else if (!r[m_owner]) begin
        m_last = m_owner; m_owner = -1;
      end else if (timeout_built() && m_hold == TB_MAX_HOLD - 1) begin
        m_last = m_owner; m_owner = -1; m_to = 1;
      end else if (m_hold < (1 << TB_CNT_W) - 1) begin
        m_hold++;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] r;
    logic       rn;
    @(posedge clk);
    r  = bus_if.req;
    rn = rst_n;
    #1;
    model_update(r, rn);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus_if.req = 4'b1111; bus_if.data_in = 4'b1111;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got %b want 0000", bus_if.grant); end
    n_cmp++; if (bus_if.sel !== 2'd0) begin n_err++; $display("FAIL reset_sel got %0d want 0", bus_if.sel); end
    n_cmp++; if (bus_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus_if.valid); end
    n_cmp++; if (bus_if.y_out !== 1'b0) begin n_err++; $display("FAIL reset_y_out got %b want 0", bus_if.y_out); end
    n_cmp++; if (bus_if.timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", bus_if.timeout); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus_if.req = 4'b0000; bus_if.data_in = 4'b0000;
    do_reset();
    bus_if.req = 4'b0100; bus_if.data_in = 4'b0100;
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", bus_if.grant); end
    n_cmp++; if (bus_if.sel !== 2'd2) begin n_err++; $display("FAIL single_sel got %0d want 2", bus_if.sel); end
    n_cmp++; if (bus_if.y_out !== 1'b1) begin n_err++; $display("FAIL single_y_out got %b want 1", bus_if.y_out); end
    bus_if.req = 4'b0000;
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL single_release got %b want 0000", bus_if.grant); end
    n_cmp++; if (bus_if.sel !== 2'd2) begin n_err++; $display("FAIL single_sel_kept got %0d want 2", bus_if.sel); end
    n_cmp++; if (bus_if.y_out !== 1'b0) begin n_err++; $display("FAIL single_idle_y_out got %b want 0", bus_if.y_out); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    bus_if.req = 4'b0000; bus_if.data_in = 4'b1010;
    do_reset();
    bus_if.req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (bus_if.grant !== exp_seq[i]) begin
        n_err++; $display("FAIL rr_step%0d got %b want %b", i, bus_if.grant, exp_seq[i]);
      end
      bus_if.req = 4'b1111 & ~exp_seq[i];
    end
  endtask

  task automatic test_contention();
    bus_if.req = 4'b0000; bus_if.data_in = 4'b0000;
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    bus_if.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus_if.grant !== 4'b0010) begin n_err++; $display("FAIL contend_hold%0d got %b want 0010", i, bus_if.grant); end
    end
    bus_if.req = 4'b0001;
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL contend_dead got %b want 0000", bus_if.grant); end
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0001) begin n_err++; $display("FAIL contend_next got %b want 0001", bus_if.grant); end
    bus_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus_if.req = 4'b0000; bus_if.data_in = 4'b1000;
    do_reset();
    bus_if.req = 4'b1000;
    tick(); tick();
    n_cmp++; if (bus_if.grant !== 4'b1000) begin n_err++; $display("FAIL midrst_busy got %b want 1000", bus_if.grant); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL midrst_grant got %b want 0000", bus_if.grant); end
    n_cmp++; if (bus_if.sel !== 2'd0) begin n_err++; $display("FAIL midrst_sel got %0d want 0", bus_if.sel); end
    rst_n = 1'b1; bus_if.req = 4'b1001;
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0001) begin n_err++; $display("FAIL midrst_after got %b want 0001", bus_if.grant); end
    bus_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_hold_limit();
    bus_if.req = 4'b0000; bus_if.data_in = 4'b0000;
    do_reset();
    bus_if.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < TB_MAX_HOLD; i++) begin
      tick();
      n_cmp++; if (bus_if.grant !== 4'b0001) begin n_err++; $display("FAIL to_hold%0d got %b want 0001", i, bus_if.grant); end
      n_cmp++; if (bus_if.timeout !== 1'b0) begin n_err++; $display("FAIL to_early%0d got %b want 0", i, bus_if.timeout); end
    end
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0000) begin n_err++; $display("FAIL to_release got %b want 0000", bus_if.grant); end
    n_cmp++; if (bus_if.timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse got %b want 1", bus_if.timeout); end
    tick();
    n_cmp++; if (bus_if.grant !== 4'b0010) begin n_err++; $display("FAIL to_next got %b want 0010", bus_if.grant); end
    n_cmp++; if (bus_if.timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse_end got %b want 0", bus_if.timeout); end
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if (bus_if.grant !== 4'b0001 || bus_if.timeout !== 1'b0) begin
        n_err++; $display("FAIL hold_unlimited%0d got grant=%b timeout=%b want 0001/0", i, bus_if.grant, bus_if.timeout);
      end
    end
`endif
    bus_if.req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_grant;
    logic [3:0] r;
    bus_if.req = 4'b0000; bus_if.data_in = 4'b0000;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom);
      // Owners usually keep requesting so holds and timeouts actually occur.
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      bus_if.req     = r;
      bus_if.data_in = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      rst_n = 1'b1;
      exp_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      n_cmp++;
      if (bus_if.grant !== exp_grant || bus_if.sel !== 2'(m_sel) ||
          bus_if.valid !== (m_owner >= 0) || bus_if.timeout !== m_to) begin
        n_err++;
        $display("FAIL rand_c%0d got g=%b s=%0d v=%b t=%b want g=%b s=%0d v=%b t=%b",
                 c, bus_if.grant, bus_if.sel, bus_if.valid, bus_if.timeout,
                 exp_grant, m_sel, (m_owner >= 0), m_to);
      end
      n_cmp++;
      if (bus_if.y_out !== ((m_owner >= 0) ? bus_if.data_in[m_sel] : 1'b0)) begin
        n_err++;
        $display("FAIL rand_y_c%0d got %b want %b", c, bus_if.y_out,
                 (m_owner >= 0) ? bus_if.data_in[m_sel] : 1'b0);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    bus_if.req = 4'b0000; bus_if.data_in = 4'b0000;
    m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0; m_to = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_reset_mid_grant();
    test_hold_limit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
